// File: rtl/rca_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH = 4;

    // Sum with its carry-out for the default width, handy for integrators.
    typedef logic [RCA_DEFAULT_WIDTH:0] rca_sum_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full-adder cell used as one stage of the carry chain.
module full_adder
    import rca_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Registered N-bit ripple-carry adder with one cycle of latency.
// Define RCA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module ripple_carry_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef RCA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] sum_comb;
    logic             carry_msb;

    // Each stage owns its carry nets so the chain is a clean feed-forward path.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_first
            assign c_in = cin;
        end else begin : g_rest
            assign c_in = g_bit[i-1].c_out;
        end

        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c_in),
            .s  (sum_comb[i]),
            .co (c_out)
        );
    end

    assign carry_msb = g_bit[WIDTH-1].c_out;

    logic [WIDTH-1:0] s_d, s_q;
    logic             co_d, co_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        s_d         = s_q;
        co_d        = co_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s_d  = sum_comb;
            co_d = carry_msb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            co_q        <= co_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign co        = co_q;
    assign out_valid = out_valid_q;

`ifdef RCA_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = carry_msb ^ g_bit[WIDTH-1].c_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (WIDTH=4) against an arithmetic reference model.
module tb_ripple_carry_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] s;
    logic         co;
`ifdef RCA_OVERFLOW_EN
    logic         ovf;
`endif

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .s         (s),
        .co        (co)
`ifdef RCA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the outputs should show after the latest edge.
    logic [W-1:0] exp_s;
    logic         exp_co;
    logic         exp_ovf;
    logic         exp_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int to_signed4(input logic [W-1:0] v);
        return (int'(v) >= 8) ? int'(v) - 16 : int'(v);
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [W-1:0] ta,
                         input logic [W-1:0] tb_in, input logic tc, input string tag);
        int sum;
        int ssum;
        rst      = r;
        in_valid = v;
        a        = ta;
        b        = tb_in;
        cin      = tc;
        @(posedge clk);
        #1;
        if (r) begin
            exp_s   = '0;
            exp_co  = 1'b0;
            exp_ovf = 1'b0;
            exp_v   = 1'b0;
        end else if (v) begin
            sum     = int'(ta) + int'(tb_in) + int'(tc);
            ssum    = to_signed4(ta) + to_signed4(tb_in) + int'(tc);
            exp_s   = sum[W-1:0];
            exp_co  = sum[W];
            exp_ovf = (ssum > 7) || (ssum < -8);
            exp_v   = 1'b1;
        end else begin
            exp_v   = 1'b0;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'(exp_v));
        check({tag, " s"},         32'(s),         32'(exp_s));
        check({tag, " co"},        32'(co),        32'(exp_co));
`ifdef RCA_OVERFLOW_EN
        check({tag, " ovf"},       32'(ovf),       32'(exp_ovf));
`endif
    endtask

    // Directed vectors {a, b, cin} with hand-derived expected {co, s}.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic       co;
        logic [3:0] s;
    } vec_t;

    vec_t dir_vecs [8] = '{
        '{4'b0001, 4'b0010, 1'b0, 1'b0, 4'b0011},
        '{4'b0010, 4'b0110, 1'b0, 1'b0, 4'b1000},
        '{4'b0111, 4'b0111, 1'b0, 1'b0, 4'b1110},
        '{4'b1001, 4'b0110, 1'b0, 1'b0, 4'b1111},
        '{4'b1100, 4'b1100, 1'b1, 1'b1, 4'b1001},
        '{4'b1111, 4'b1110, 1'b1, 1'b1, 4'b1110},
        '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111},
        '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000}
    };

    initial begin
        exp_s    = '0;
        exp_co   = 1'b0;
        exp_ovf  = 1'b0;
        exp_v    = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 4'hF;
        b        = 4'hF;
        cin      = 1'b1;

        // Reset dominates a valid operand set.
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, "reset");
            check("reset s const", 32'(s), 32'h0);
        end

        // Directed sums, also checked against the hand-written table.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].c, "directed");
            check("directed table s",  32'(s),  32'(dir_vecs[i].s));
            check("directed table co", 32'(co), 32'(dir_vecs[i].co));
        end

        // Hold: valid result, then two idle cycles with junk on the operands.
        cycle(1'b0, 1'b1, 4'b1010, 4'b0111, 1'b1, "pre-hold");
        check("pre-hold s const", 32'(s), 32'h2);
        cycle(1'b0, 1'b0, 4'b0101, 4'b0101, 1'b0, "hold1");
        cycle(1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, "hold2");
        check("hold s const", 32'(s), 32'h2);

        // Reset mid-stream discards the in-flight result.
        cycle(1'b0, 1'b1, 4'b0110, 4'b0101, 1'b0, "pre-rst");
        cycle(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, "mid-rst");
        cycle(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0, "post-rst");

`ifdef RCA_OVERFLOW_EN
        cycle(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0, "ovf pos");
        check("ovf pos const", 32'(ovf), 32'h1);
        cycle(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, "ovf neg");
        check("ovf neg const", 32'(ovf), 32'h1);
        cycle(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0, "ovf none");
        check("ovf none const", 32'(ovf), 32'h0);
`endif

        // Exhaustive sweep of all operand combinations.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            cycle(1'b0, 1'b1, v[8:5], v[4:1], v[0], "sweep");
        end

        // Random traffic with gaps and occasional resets.
        for (int i = 0; i < 300; i++) begin
            logic r_r, r_v, r_c;
            logic [W-1:0] r_a, r_b;
            r_r = ($urandom_range(0, 19) == 0);
            r_v = ($urandom_range(0, 3) != 0);
            r_a = W'($urandom);
            r_b = W'($urandom);
            r_c = 1'($urandom);
            cycle(r_r, r_v, r_a, r_b, r_c, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
